rng_commit_gen: RTL and testbench

- Pseudo-random register-writeback generator that stands in for a CPU commit stage in co-simulation against the Spike reference model.
- Every clock it presents two write ports: address, data and write-enable per port.
- A bench collects the enabled writes into an address→data map, with port 2 overriding port 1, and compares that map against the reference model's last commit.
- Fully deterministic for a given SEED.

---
 rtl/rng_commit_gen.sv | 151 +++++++++++++++
 tb/tb_rng_commit_gen.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rng_commit_gen.sv
// rng_commit_gen: pseudo-random register-writeback generator that stands in
// for a CPU commit stage. A bank of independent 32-bit xorshift lanes is
// stepped every clock, and the lanes are sliced into two write ports
// (address, data, enable) that are presented from registers.
module rng_commit_gen #(
    parameter int unsigned DPI_WIDTH   = 32,
    parameter int unsigned KEY_WIDTH   = 64,
    parameter int unsigned VALUE_WIDTH = 128,
    parameter int unsigned ADDR_BITS   = 5,
    parameter logic [31:0] SEED        = 32'h1234_5678
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    output logic [KEY_WIDTH-1:0]   last_wa1_o,
    output logic [VALUE_WIDTH-1:0] last_wd1_o,
    output logic                   last_we1_o,
    output logic [KEY_WIDTH-1:0]   last_wa2_o,
    output logic [VALUE_WIDTH-1:0] last_wd2_o,
    output logic                   last_we2_o
);

    // Every lane is 32 bits wide; the chunk width is fixed to the lane width.
    localparam int unsigned CW = 32;
    localparam int unsigned NK = KEY_WIDTH / DPI_WIDTH;
    localparam int unsigned NV = VALUE_WIDTH / DPI_WIDTH;
    localparam int unsigned L  = 2 * (NK + NV) + 1;

    // Lane index bases for each field, in allocation order.
    localparam int unsigned WA1_BASE = 0;
    localparam int unsigned WD1_BASE = NK;
    localparam int unsigned WA2_BASE = NK + NV;
    localparam int unsigned WD2_BASE = 2 * NK + NV;
    localparam int unsigned EN_LANE  = L - 1;

    // Only the low ADDR_BITS of an address are random; the rest read as 0.
    localparam logic [KEY_WIDTH-1:0] ADDR_MASK =
        {KEY_WIDTH{1'b1}} >> (KEY_WIDTH - ADDR_BITS);

    // Golden-ratio increment spreads the per-lane seeds across the space.
    localparam logic [31:0] SEED_STRIDE = 32'h9E37_79B9;

    // ------------------------------------------------------------------
    // Parameter legality
    // ------------------------------------------------------------------
    if (DPI_WIDTH != 32) begin : g_bad_dpi_width
        $error("rng_commit_gen: DPI_WIDTH must be 32");
    end

    if ((KEY_WIDTH == 0) || (KEY_WIDTH % DPI_WIDTH != 0)) begin : g_bad_key_width
        $error("rng_commit_gen: KEY_WIDTH must be a non-zero multiple of DPI_WIDTH");
    end

    if ((VALUE_WIDTH == 0) || (VALUE_WIDTH % DPI_WIDTH != 0)) begin : g_bad_value_width
        $error("rng_commit_gen: VALUE_WIDTH must be a non-zero multiple of DPI_WIDTH");
    end

    if ((ADDR_BITS < 1) || (ADDR_BITS > KEY_WIDTH)) begin : g_bad_addr_bits
        $error("rng_commit_gen: ADDR_BITS must lie in 1..KEY_WIDTH");
    end

    // ------------------------------------------------------------------
    // Lane arithmetic
    // ------------------------------------------------------------------

    // Seed of lane k; an all-zero xorshift state would stick at zero forever,
    // so a seed that works out to 0 is replaced by 1.
    function automatic logic [31:0] lane_seed(input int unsigned k);
        logic [31:0] s;
        s = SEED + 32'(k) * SEED_STRIDE;
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

    // One xorshift32 step (13, 17, 5), applied in that order.
    function automatic logic [31:0] xs_step(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    logic [CW-1:0]          lane_q [L];
    logic [CW-1:0]          lane_d [L];
    logic [KEY_WIDTH-1:0]   wa1_d;
    logic [KEY_WIDTH-1:0]   wa2_d;
    logic [VALUE_WIDTH-1:0] wd1_d;
    logic [VALUE_WIDTH-1:0] wd2_d;

    // Next state of every lane: one xorshift step from the current state.
    always_comb begin
        for (int unsigned k = 0; k < L; k++) begin
            lane_d[k] = xs_step(lane_q[k]);
        end
    end

    // Slice the next lane states into the four wide fields, chunk i of a
    // field coming from the i-th lane of that field's group.
    always_comb begin
        // NOTE: every combinational output gets a default before any loop or
        // branch, so no path leaves it unassigned and no latch is inferred.
        wa1_d = '0;
        wa2_d = '0;
        wd1_d = '0;
        wd2_d = '0;
        for (int unsigned i = 0; i < NK; i++) begin
            wa1_d[i*CW +: CW] = lane_d[WA1_BASE + i];
            wa2_d[i*CW +: CW] = lane_d[WA2_BASE + i];
        end
        for (int unsigned i = 0; i < NV; i++) begin
            wd1_d[i*CW +: CW] = lane_d[WD1_BASE + i];
            wd2_d[i*CW +: CW] = lane_d[WD2_BASE + i];
        end
    end

    // Lane state: reload seeds on reset, otherwise advance one step.
    always_ff @(posedge clk_i) begin
        // NOTE: the lane array is real generator state, not a data store, so
        // it is reset to its seeds; sequential state uses non-blocking <= so
        // every register samples the pre-edge values of its sources.
        if (rst_i) begin
            for (int unsigned k = 0; k < L; k++) begin
                lane_q[k] <= lane_seed(k);
            end
        end else begin
            for (int unsigned k = 0; k < L; k++) begin
                lane_q[k] <= lane_d[k];
            end
        end
    end

    // Output registers: cleared on reset, otherwise loaded from the fields of
    // the same next state the lanes are taking, so edge N shows step N.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_wa1_o <= '0;
            last_wd1_o <= '0;
            last_we1_o <= 1'b0;
            last_wa2_o <= '0;
            last_wd2_o <= '0;
            last_we2_o <= 1'b0;
        end else begin
            last_wa1_o <= wa1_d & ADDR_MASK;
            last_wd1_o <= wd1_d;
            last_we1_o <= lane_d[EN_LANE][0];
            last_wa2_o <= wa2_d & ADDR_MASK;
            last_wd2_o <= wd2_d;
            last_we2_o <= lane_d[EN_LANE][1];
        end
    end

endmodule

// File: tb/tb_rng_commit_gen.sv
// tb_rng_commit_gen: three generator instances (default seed with 5 random
// address bits, SEED=1 and SEED=0 with full-width addresses) checked every
// cycle against a behavioural model, under randomized reset stimulus.
module tb_rng_commit_gen;

    localparam int KW = 64;
    localparam int VW = 128;
    localparam int NK = KW / 32;
    localparam int NV = VW / 32;
    localparam int L  = 2 * (NK + NV) + 1;
    localparam int NI = 3;

    localparam logic [31:0] SEEDS [NI] = '{32'h1234_5678, 32'h1, 32'h0};
    localparam int          ABITS [NI] = '{5, 64, 64};

    typedef logic [L-1:0][31:0] lanes_t;

    typedef struct packed {
        logic [KW-1:0] wa1;
        logic [VW-1:0] wd1;
        logic          we1;
        logic [KW-1:0] wa2;
        logic [VW-1:0] wd2;
        logic          we2;
    } ports_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    wire [KW-1:0] wa1 [NI];
    wire [VW-1:0] wd1 [NI];
    wire          we1 [NI];
    wire [KW-1:0] wa2 [NI];
    wire [VW-1:0] wd2 [NI];
    wire          we2 [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        rng_commit_gen #(
            .DPI_WIDTH  (32),
            .KEY_WIDTH  (KW),
            .VALUE_WIDTH(VW),
            .ADDR_BITS  (ABITS[g]),
            .SEED       (SEEDS[g])
        ) u_dut (
            .clk_i     (clk),
            .rst_i     (rst),
            .last_wa1_o(wa1[g]),
            .last_wd1_o(wd1[g]),
            .last_we1_o(we1[g]),
            .last_wa2_o(wa2[g]),
            .last_wd2_o(wd2[g]),
            .last_we2_o(we2[g])
        );
    end

    // ------------------------------------------------------------------
    // Counters and check task
    // ------------------------------------------------------------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    function automatic lanes_t model_seeds(input logic [31:0] base);
        lanes_t      r;
        logic [63:0] s;
        for (int k = 0; k < L; k++) begin
            s = 64'(base) + 64'(k) * 64'd2654435769;
            r[k] = (s[31:0] == 32'd0) ? 32'd1 : s[31:0];
        end
        return r;
    endfunction

    function automatic lanes_t model_advance(input lanes_t x);
        lanes_t r;
        for (int k = 0; k < L; k++) begin
            r[k] = x[k] ^ (x[k] << 13);
            r[k] = r[k] ^ (r[k] >> 17);
            r[k] = r[k] ^ (r[k] << 5);
        end
        return r;
    endfunction

    function automatic ports_t model_ports(input lanes_t x, input int abits);
        ports_t        p;
        logic [KW-1:0] mask;
        mask = (abits >= KW) ? {KW{1'b1}} : ((64'd1 << abits) - 64'd1);
        p = '0;
        for (int i = 0; i < NK; i++) begin
            p.wa1[32*i +: 32] = x[i];
            p.wa2[32*i +: 32] = x[NK + NV + i];
        end
        for (int i = 0; i < NV; i++) begin
            p.wd1[32*i +: 32] = x[NK + i];
            p.wd2[32*i +: 32] = x[2*NK + NV + i];
        end
        p.wa1 = p.wa1 & mask;
        p.wa2 = p.wa2 & mask;
        p.we1 = x[L-1][0];
        p.we2 = x[L-1][1];
        return p;
    endfunction

    lanes_t m_lane [NI];
    ports_t exp_p  [NI];
    logic   model_valid = 1'b0;

    // Model tracks each instance: seeds on reset, one step otherwise.
    always @(posedge clk) begin
        for (int n = 0; n < NI; n++) begin
            if (rst) begin
                m_lane[n] <= model_seeds(SEEDS[n]);
                exp_p[n]  <= '0;
            end else begin
                m_lane[n] <= model_advance(m_lane[n]);
                exp_p[n]  <= model_ports(model_advance(m_lane[n]), ABITS[n]);
            end
        end
        if (rst) model_valid <= 1'b1;
    end

    // ------------------------------------------------------------------
    // Per-cycle compare, map check and coverage
    // ------------------------------------------------------------------
    logic [VW-1:0] dut_map [logic [KW-1:0]];
    logic [VW-1:0] exp_map [logic [KW-1:0]];
    bit saw_we1_0, saw_we1_1, saw_we2_0, saw_we2_1, saw_collision;

    always @(negedge clk) begin
        if (model_valid) begin
            for (int n = 0; n < NI; n++) begin
                check($sformatf("i%0d_wa1", n), 128'(wa1[n]), 128'(exp_p[n].wa1));
                check($sformatf("i%0d_wd1", n), wd1[n], exp_p[n].wd1);
                check($sformatf("i%0d_we1", n), 128'(we1[n]), 128'(exp_p[n].we1));
                check($sformatf("i%0d_wa2", n), 128'(wa2[n]), 128'(exp_p[n].wa2));
                check($sformatf("i%0d_wd2", n), wd2[n], exp_p[n].wd2);
                check($sformatf("i%0d_we2", n), 128'(we2[n]), 128'(exp_p[n].we2));
            end

            check("wa1_range", 128'(wa1[0] < 64'd32), 128'(1));
            check("wa2_range", 128'(wa2[0] < 64'd32), 128'(1));

            dut_map.delete();
            exp_map.delete();
            if (we1[0] === 1'b1) dut_map[wa1[0]] = wd1[0];
            if (we2[0] === 1'b1) dut_map[wa2[0]] = wd2[0];
            if (exp_p[0].we1) exp_map[exp_p[0].wa1] = exp_p[0].wd1;
            if (exp_p[0].we2) exp_map[exp_p[0].wa2] = exp_p[0].wd2;
            check("map_size", 128'(dut_map.size()), 128'(exp_map.size()));
            foreach (exp_map[a]) begin
                check("map_entry", dut_map.exists(a) ? dut_map[a] : {VW{1'bx}}, exp_map[a]);
            end

            if (we1[0] === 1'b0) saw_we1_0 = 1'b1;
            if (we1[0] === 1'b1) saw_we1_1 = 1'b1;
            if (we2[0] === 1'b0) saw_we2_0 = 1'b1;
            if (we2[0] === 1'b1) saw_we2_1 = 1'b1;
            if ((we1[0] === 1'b1) && (we2[0] === 1'b1) && (wa1[0] === wa2[0]))
                saw_collision = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Directed sequence followed by randomized resets
    // ------------------------------------------------------------------
    task automatic check_zero(input string tag);
        check({tag, "_wa1"}, 128'(wa1[0]), 128'(0));
        check({tag, "_wd1"}, wd1[0], 128'(0));
        check({tag, "_we1"}, 128'(we1[0]), 128'(0));
        check({tag, "_wa2"}, 128'(wa2[0]), 128'(0));
        check({tag, "_wd2"}, wd2[0], 128'(0));
        check({tag, "_we2"}, 128'(we2[0]), 128'(0));
    endtask

    ports_t rec [7];

    initial begin
        rst = 1'b1;
        for (int e = 0; e < 2; e++) begin
            @(posedge clk);
            #1;
            check_zero($sformatf("reset_edge%0d", e));
        end
        check("model_seed_lane1", 128'(m_lane[0][1]), 128'(32'hB06B_D031));
        check("model_zero_guard", 128'(m_lane[2][0]), 128'(32'h1));

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("seed1_first_wa1", 128'(wa1[1][31:0]), 128'(32'h0004_2021));
        check("seed0_first_wa1", 128'(wa1[2][31:0]), 128'(32'h0004_2021));
        check("model_first_step", 128'(exp_p[1].wa1[31:0]), 128'(32'h0004_2021));
        rec[0] = exp_p[0];
        for (int i = 1; i < 7; i++) begin
            @(posedge clk);
            #1;
            rec[i] = exp_p[0];
        end

        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_zero("midrun_reset");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("det%0d_wa1", i), 128'(wa1[0]), 128'(rec[i].wa1));
            check($sformatf("det%0d_wd1", i), wd1[0], rec[i].wd1);
            check($sformatf("det%0d_we1", i), 128'(we1[0]), 128'(rec[i].we1));
            check($sformatf("det%0d_wa2", i), 128'(wa2[0]), 128'(rec[i].wa2));
            check($sformatf("det%0d_wd2", i), wd2[0], rec[i].wd2);
            check($sformatf("det%0d_we2", i), 128'(we2[0]), 128'(rec[i].we2));
        end

        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 99) < 2);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        check("cov_we1_zero", 128'(saw_we1_0), 128'(1));
        check("cov_we1_one", 128'(saw_we1_1), 128'(1));
        check("cov_we2_zero", 128'(saw_we2_0), 128'(1));
        check("cov_we2_one", 128'(saw_we2_1), 128'(1));
        check("cov_collision", 128'(saw_collision), 128'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
